bcd_tick_counter: RTL and testbench
===================================

# bcd_tick_counter

Parametrised successor to the 0-9 seconds counter: a clock prescaler driving a cascaded multi-digit BCD counter with programmable modulus, up/down mode, enable and synchronous load. It generates its own tick and wrap pulses. It sits between the system clock and the display/timekeeping logic, and several instances can be chained via `wrap` → `en` to build seconds, minutes and hours.

## Interface
Parameters:
- `CLK_DIV`, default 24000: enabled clock cycles per tick (≥1; 24000000 for 1 s at 24 MHz in silicon).
- `DIV_W`, default 25: prescaler counter width; must satisfy 2^DIV_W > CLK_DIV-1.
- `DIGITS`, default 2: number of BCD digits.
- `MODULUS`, default 60: count range 0..MODULUS-1 (2 ≤ MODULUS ≤ 10^DIGITS).

Ports:
- `clk`, input, 1: single clock, rising edge.
- `res`, input, 1: reset, asynchronous, active-high.
- `en`, input, 1: advance enable; low freezes prescaler and count.
- `up`, input, 1: 1 = count up, 0 = count down.
- `load`, input, 1: synchronous load strobe.
- `load_val`, input, 4*DIGITS: BCD load value; digit 0 occupies bits [3:0].
- `tick`, output, 1: registered one-cycle tick pulse.
- `bcd`, output, 4*DIGITS: registered BCD count; digit 0 is least significant.
- `wrap`, output, 1: registered one-cycle pulse on modulus wrap.

## Operation
- **Reset** (`res`=1, immediate, asynchronous):
  - prescaler = 0.
  - `tick` = 0, `bcd` = 0, `wrap` = 0.
- **Per-edge priority:** load > en. When not loading, `wrap` defaults to 0 every edge.
- **Load** (`load`=1):
  - `bcd` ← `load_val` if every digit ≤ 9 and the value < MODULUS; otherwise `bcd` ← 0.
  - prescaler ← 0, `tick` ← 0, `wrap` ← 0.
  - `en`, `up` and `tick` are ignored on that edge.
- **Prescaler, `en`=1:**
  - If prescaler == CLK_DIV-1: prescaler ← 0 and `tick` ← 1.
  - Otherwise: prescaler +1 and `tick` ← 0.
- **Prescaler, `en`=0:** prescaler holds and `tick` ← 0. A pending tick is dropped and the count does not advance.
- **Count step:** on an edge with `tick`=1 and `en`=1 (no load), `bcd` steps once.
  - Up, value == MODULUS-1: `bcd` ← 0 and `wrap` ← 1.
  - Up, otherwise: BCD increment. Digit 9→0 carries +1 into the next digit.
  - Down, value == 0: `bcd` ← MODULUS-1 (in BCD) and `wrap` ← 1.
  - Down, otherwise: BCD decrement. Digit 0→9 borrows from the next digit.
- **Binary never appears on `bcd`:** every digit stays 0-9 at all times. MODULUS-1 is converted to a BCD constant at elaboration.
- **`up` changes** take effect on the next step; no internal state depends on direction.

## Timing
- With `en` held high after reset release, `tick` rises after the CLK_DIV-th enabled edge.
- `bcd` changes on the following edge, so there is 1 cycle of tick→count latency.
- `tick` period is CLK_DIV cycles with high time 1 cycle.
  - Exception, CLK_DIV=1: `tick` stays high continuously after the first enabled edge, and `bcd` steps every cycle.
- `wrap` is asserted in the same cycle `bcd` shows the wrapped value, for exactly 1 cycle.
- Cascading `wrap` into the next stage's `en` therefore gives that stage a one-cycle enable. The next stage should use CLK_DIV=1.
- **Load timing:** `bcd` shows the loaded value 1 cycle after the `load` edge. The next tick follows CLK_DIV enabled cycles later.
- **Simultaneous load and tick:** the load wins; no step and no `wrap`.
- **Reset mid-count:** outputs clear without waiting for `clk`. After `res` falls, the first tick arrives a full CLK_DIV enabled cycles later.

## Test plan
Default bench configuration: CLK_DIV=4, DIGITS=2, MODULUS=60, 10 ns clock.
1. **Reset and first step:** hold `res`=1 for 17 ns, then release with `en`=1, `up`=1. Required: `tick` high on the 4th edge after release, `bcd` = 0x01 on the 5th; thereafter +1 every 4 cycles.
2. **Up wrap:** load 0x58, `en`=1, `up`=1. Required: `bcd` 0x59 then 0x00, with `wrap`=1 for one cycle coincident with 0x00. Also check 0x09→0x10 carry.
3. **Down wrap:** load 0x01, `up`=0. Required: `bcd` 0x00, then 0x59 with `wrap`=1. Also check 0x10→0x09 borrow.
4. **Enable freeze:**
   - Drop `en` for 7 cycles mid-prescale. Required: `bcd` unchanged; the tick resumes after the remaining enabled cycles.
   - Drop `en` exactly in the `tick`-high cycle. Required: that step is lost.
5. **Load priority and invalid value:**
   - Assert `load` with 0x35 in a `tick`-high cycle. Required: `bcd` = 0x35, no step, no `wrap`.
   - Load 0x7A, then 0x60. Required: each gives `bcd` = 0x00.
6. **Async reset and CLK_DIV=1:**
   - Assert `res` between clock edges. Required: `bcd`, `tick` and `wrap` go to 0 before the next edge.
   - Second instance with CLK_DIV=1, MODULUS=10, DIGITS=1. Required: counts 0-9 one per cycle, with `wrap` at each 9→0.

Source files
------------

// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: clock prescaler driving a cascaded BCD counter with modulus, up/down, enable and load
module bcd_tick_counter #(
  parameter int CLK_DIV = 24000,
  parameter int DIV_W = 25,
  parameter int DIGITS = 2,
  parameter int MODULUS = 60
) (
  input  logic                clk,
  input  logic                res,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic                tick,
  output logic [4*DIGITS-1:0] bcd,
  output logic                wrap
);
  localparam int BW = 4*DIGITS;
  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i+:4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction
  localparam logic [BW-1:0] TOP = to_bcd(MODULUS - 1);
  localparam logic [DIV_W-1:0] DIV_END = DIV_W'(CLK_DIV - 1);
  logic [DIV_W-1:0] div;
  logic [BW-1:0] inc, dec, ld_bin, w, nxt;
  logic c, b, ld_digits_ok, ld_ok, at_end;
  // Digit-wise carry/borrow chains keep every digit in 0-9
  always_comb begin
    inc = bcd;
    dec = bcd;
    c = 1'b1;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      inc[4*i+:4] = c ? ((bcd[4*i+:4] == 4'd9) ? 4'd0 : bcd[4*i+:4] + 4'd1) : bcd[4*i+:4];
      dec[4*i+:4] = b ? ((bcd[4*i+:4] == 4'd0) ? 4'd9 : bcd[4*i+:4] - 4'd1) : bcd[4*i+:4];
      c = c & (bcd[4*i+:4] == 4'd9);
      b = b & (bcd[4*i+:4] == 4'd0);
    end
  end
  always_comb begin
    ld_digits_ok = 1'b1;
    ld_bin = '0;
    w = BW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      ld_digits_ok = ld_digits_ok & (load_val[4*i+:4] <= 4'd9);
      ld_bin = ld_bin + BW'(load_val[4*i+:4]) * w;
      w = w * BW'(10);
    end
  end
  assign ld_ok = ld_digits_ok & (ld_bin < BW'(MODULUS));
  assign at_end = up ? (bcd == TOP) : (bcd == '0);
  assign nxt = at_end ? (up ? '0 : TOP) : (up ? inc : dec);
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      div  <= '0;
      tick <= 1'b0;
      bcd  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      div  <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
      bcd  <= ld_ok ? load_val : '0;
    end else begin
      wrap <= en & tick & at_end;
      if (en) begin
        div  <= (div == DIV_END) ? '0 : div + DIV_W'(1);
        tick <= div == DIV_END;
        if (tick) bcd <= nxt;
      end else begin
        tick <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bcd_tick_counter.sv
// tb_bcd_tick_counter: table-driven and scoreboard checks of two counter instances
module tb_bcd_tick_counter;
  logic clk = 1'b0, res = 1'b1, en = 1'b1, up = 1'b1, load = 1'b0;
  logic [7:0] load_val = '0;
  logic tick, wrap;
  logic [7:0] bcd;
  logic en2 = 1'b0, up2 = 1'b1, load2 = 1'b0;
  logic [3:0] load_val2 = '0;
  logic tick2, wrap2;
  logic [3:0] bcd2;
  int errors = 0, checks = 0;
  int m_div = 0, m_cnt = 0, m2_cnt = 0;
  bit m_tick = 0, m_wrap = 0, m2_tick = 0, m2_wrap = 0;
  typedef struct {
    logic e, u, l;
    logic [7:0] lv;
    int n;
    logic [7:0] xb;
    logic xt, xw;
  } vec_t;
  typedef struct {
    logic t, w, t2, w2;
    logic [7:0] b;
    logic [3:0] b2;
  } exp_t;
  exp_t q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  bcd_tick_counter #(.CLK_DIV(4), .DIV_W(3), .DIGITS(2), .MODULUS(60)) dut (
    .clk(clk), .res(res), .en(en), .up(up), .load(load), .load_val(load_val),
    .tick(tick), .bcd(bcd), .wrap(wrap)
  );
  bcd_tick_counter #(.CLK_DIV(1), .DIV_W(1), .DIGITS(1), .MODULUS(10)) dut2 (
    .clk(clk), .res(res), .en(en2), .up(up2), .load(load2), .load_val(load_val2),
    .tick(tick2), .bcd(bcd2), .wrap(wrap2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd8(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  task automatic model_reset();
    m_div = 0; m_cnt = 0; m_tick = 0; m_wrap = 0;
    m2_cnt = 0; m2_tick = 0; m2_wrap = 0;
  endtask

  // Integer reference model; expected outputs are queued and compared after the edge
  task automatic step(input logic e, input logic u, input logic l, input logic [7:0] lv);
    exp_t x;
    int val;
    @(negedge clk);
    en = e; up = u; load = l; load_val = lv;
    val = int'(lv[7:4]) * 10 + int'(lv[3:0]);
    if (l) begin
      m_cnt = (lv[7:4] <= 9 && lv[3:0] <= 9 && val < 60) ? val : 0;
      m_div = 0; m_tick = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (e) begin
        if (m_tick) begin
          if (u) begin
            m_wrap = (m_cnt == 59);
            m_cnt = (m_cnt + 1) % 60;
          end else begin
            m_wrap = (m_cnt == 0);
            m_cnt = (m_cnt + 59) % 60;
          end
        end
        m_tick = (m_div == 3);
        m_div = (m_div + 1) % 4;
      end else begin
        m_tick = 0;
      end
    end
    m2_wrap = 0;
    if (en2) begin
      if (m2_tick) begin
        m2_wrap = (m2_cnt == 9);
        m2_cnt = (m2_cnt + 1) % 10;
      end
      m2_tick = 1;
    end else begin
      m2_tick = 0;
    end
    x.t = m_tick; x.w = m_wrap; x.b = to_bcd8(m_cnt);
    x.t2 = m2_tick; x.w2 = m2_wrap; x.b2 = 4'(m2_cnt);
    q.push_back(x);
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk("sb tick", tick, x.t);
    chk("sb bcd", bcd, x.b);
    chk("sb wrap", wrap, x.w);
    chk("sb tick2", tick2, x.t2);
    chk("sb bcd2", bcd2, x.b2);
    chk("sb wrap2", wrap2, x.w2);
  endtask

  initial begin
    tbl.push_back('{1, 1, 0, 8'h00, 4, 8'h00, 1, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 1, 8'h01, 0, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 8, 8'h03, 0, 0});
    tbl.push_back('{1, 1, 1, 8'h58, 1, 8'h58, 0, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 5, 8'h59, 0, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 4, 8'h00, 0, 1});
    tbl.push_back('{1, 1, 0, 8'h00, 1, 8'h00, 0, 0});
    tbl.push_back('{1, 1, 1, 8'h09, 1, 8'h09, 0, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 5, 8'h10, 0, 0});
    tbl.push_back('{1, 0, 1, 8'h01, 1, 8'h01, 0, 0});
    tbl.push_back('{1, 0, 0, 8'h00, 5, 8'h00, 0, 0});
    tbl.push_back('{1, 0, 0, 8'h00, 4, 8'h59, 0, 1});
    tbl.push_back('{1, 0, 1, 8'h10, 1, 8'h10, 0, 0});
    tbl.push_back('{1, 0, 0, 8'h00, 5, 8'h09, 0, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 1, 8'h09, 0, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 7, 8'h09, 0, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 2, 8'h09, 1, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 1, 8'h10, 0, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 2, 8'h10, 0, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 1, 8'h10, 1, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 1, 8'h10, 0, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 4, 8'h10, 1, 0});
    tbl.push_back('{1, 1, 1, 8'h35, 1, 8'h35, 0, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 4, 8'h35, 1, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 1, 8'h36, 0, 0});
    tbl.push_back('{1, 1, 1, 8'h59, 1, 8'h59, 0, 0});
    tbl.push_back('{1, 1, 1, 8'h7A, 1, 8'h00, 0, 0});
    tbl.push_back('{1, 1, 1, 8'h59, 1, 8'h59, 0, 0});
    tbl.push_back('{1, 1, 1, 8'h60, 1, 8'h00, 0, 0});
    tbl.push_back('{1, 1, 1, 8'h42, 1, 8'h42, 0, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 4, 8'h42, 1, 0});

    #16;
    chk("reset bcd", bcd, 8'h00);
    chk("reset tick", tick, 0);
    chk("reset wrap", wrap, 0);
    #1 res = 1'b0;
    model_reset();
    for (int r = 0; r < tbl.size(); r++) begin
      for (int k = 0; k < tbl[r].n; k++) step(tbl[r].e, tbl[r].u, tbl[r].l, tbl[r].lv);
      chk($sformatf("row%0d bcd", r), bcd, tbl[r].xb);
      chk($sformatf("row%0d tick", r), tick, tbl[r].xt);
      chk($sformatf("row%0d wrap", r), wrap, tbl[r].xw);
    end

    #1 res = 1'b1;
    #1;
    chk("async bcd", bcd, 8'h00);
    chk("async tick", tick, 0);
    chk("async wrap", wrap, 0);
    chk("async bcd2", bcd2, 0);
    #1 res = 1'b0;
    en2 = 1'b1;
    model_reset();
    for (int k = 1; k <= 25; k++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      if (k == 3) chk("post-reset tick early", tick, 0);
      if (k == 4) chk("post-reset tick", tick, 1);
      if (k == 5) chk("post-reset first step", bcd, 8'h01);
      if (k == 10) chk("div1 bcd2 nine", bcd2, 9);
      if (k == 11) begin
        chk("div1 wrap2", wrap2, 1);
        chk("div1 bcd2 zero", bcd2, 0);
        chk("div1 tick2 steady", tick2, 1);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
